// File: rtl/lsu_ctrl_r0.sv
// lsu_ctrl_r0: MIPS memory-stage load/store control placed ahead of the byte-lane data RAM.
// Latency: a store strobes ram_wren in the cycle after accept; load data is registered READ_LAT edges after accept.
// Backpressure: one request in flight; req_ready is low outside IDLE, including while a result waits for rsp_ready.
// Optional feature: define LSU_ALIGN_CHECK_EN to reject misaligned half/word requests via err_valid/err_addr.
module lsu_ctrl_r0 #(
    parameter int BIT_WIDTH = 32,
    parameter int READ_LAT  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_wr,
    input  logic                 req_signed,
    input  logic [1:0]           req_size,
    input  logic [7:0]           req_addr,
    input  logic [BIT_WIDTH-1:0] req_wdata,
    input  logic [4:0]           req_rd,
    output logic [7:0]           ram_addr,
    output logic [BIT_WIDTH-1:0] ram_data,
    output logic                 ram_wren,
    output logic                 ram_isSigned,
    output logic [1:0]           ram_dataSize,
    input  logic [BIT_WIDTH-1:0] ram_q,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [BIT_WIDTH-1:0] rsp_data,
    output logic [4:0]           rsp_rd,
    output logic                 err_valid,
    output logic [7:0]           err_addr
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;
    localparam logic [1:0] S_RESP   = 2'd3;

    // The count covers the ACCESS cycle too, so zero in ACCESS means capture at the end of ACCESS.
    localparam logic [1:0] CNT_INIT = 2'(READ_LAT - 1);

    logic [1:0]           state_q, state_d;
    logic [1:0]           cnt_q, cnt_d;
    logic                 capture;
    logic                 accept;
    logic                 misalign;
    logic                 busy;

    logic                 wr_q;
    logic                 signed_q;
    logic [1:0]           size_q;
    logic [7:0]           addr_q;
    logic [BIT_WIDTH-1:0] wdata_q;
    logic [4:0]           rd_q;
    logic [BIT_WIDTH-1:0] rsp_data_q;
    logic [4:0]           rsp_rd_q;
    logic [BIT_WIDTH-1:0] lane_data;

    assign accept = (state_q == S_IDLE) && req_valid;
    assign busy   = (state_q != S_IDLE);

`ifdef LSU_ALIGN_CHECK_EN
    logic       err_valid_q;
    logic [7:0] err_addr_q;

    assign misalign = ((req_size == 2'b01) && req_addr[0]) ||
                      (req_size[1] && (req_addr[1:0] != 2'b00));

    // One-cycle error pulse on a rejected request; the address is held until the next error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_valid_q <= 1'b0;
            err_addr_q  <= 8'h00;
        end else begin
            err_valid_q <= accept && misalign;
            if (accept && misalign) begin
                err_addr_q <= req_addr;
            end
        end
    end

    assign err_valid = err_valid_q;
    assign err_addr  = err_addr_q;
`else
    assign misalign  = 1'b0;
    assign err_valid = 1'b0;
    assign err_addr  = 8'h00;
`endif

    // Next-state and read-latency countdown; capture marks the edge where ram_q is valid.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid && !misalign) begin
                    state_d = S_ACCESS;
                    cnt_d   = CNT_INIT;
                end
            end
            S_ACCESS, S_WAIT: begin
                if ((state_q == S_ACCESS) && wr_q) begin
                    state_d = S_IDLE;
                end else if (cnt_q == 2'd0) begin
                    state_d = S_RESP;
                    capture = 1'b1;
                end else begin
                    state_d = S_WAIT;
                    cnt_d   = cnt_q - 2'd1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, request latch (IDLE only, so RAM controls stay frozen until capture) and result register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= 2'd0;
            wr_q       <= 1'b0;
            signed_q   <= 1'b0;
            size_q     <= 2'b00;
            addr_q     <= 8'h00;
            wdata_q    <= '0;
            rd_q       <= 5'd0;
            rsp_data_q <= '0;
            rsp_rd_q   <= 5'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                wr_q     <= req_wr;
                signed_q <= req_signed;
                // Size 11 is a word access; normalise here so the RAM only sees 00/01/10.
                size_q   <= (req_size == 2'b11) ? 2'b10 : req_size;
                addr_q   <= req_addr;
                wdata_q  <= req_wdata;
                rd_q     <= req_rd;
            end
            if (capture) begin
                rsp_data_q <= ram_q;
                rsp_rd_q   <= rd_q;
            end
        end
    end

    // Replicate right-justified store data across every lane the access size could select.
    always_comb begin
        lane_data = wdata_q;
        case (size_q)
            2'b00:   lane_data = {4{wdata_q[7:0]}};
            2'b01:   lane_data = {2{wdata_q[15:0]}};
            default: lane_data = wdata_q;
        endcase
    end

    // req_ready is gated by rst_n so it reads low for the whole reset window.
    assign req_ready    = (state_q == S_IDLE) && rst_n;
    assign ram_addr     = busy ? addr_q : 8'h00;
    assign ram_dataSize = busy ? size_q : 2'b00;
    assign ram_isSigned = busy && signed_q;
    assign ram_data     = busy ? lane_data : '0;
    assign ram_wren     = (state_q == S_ACCESS) && wr_q;
    assign rsp_valid    = (state_q == S_RESP);
    assign rsp_data     = rsp_data_q;
    assign rsp_rd       = rsp_rd_q;

endmodule
